// File: rtl/cfg_seq_pkg.sv
// Shared types and constants for the configuration sequencer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package cfg_seq_pkg;

    // Sequencer states; the four stage states run strictly in this order.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DATA = 3'd1,
        ST_WICP = 3'd2,
        ST_TMPC = 3'd3,
        ST_POST = 3'd4
    } seq_state_e;

    // Stage indices into the start/done vectors.
    localparam int unsigned NUM_STAGES = 4;
    localparam logic [1:0]  STG_DATA   = 2'd0;
    localparam logic [1:0]  STG_WICP   = 2'd1;
    localparam logic [1:0]  STG_TMPC   = 2'd2;
    localparam logic [1:0]  STG_POST   = 2'd3;

    // Default config word widths.
    localparam int unsigned DEF_DATA_CWIDTH = 32;
    localparam int unsigned DEF_WICP_CWIDTH = 32;
    localparam int unsigned DEF_TMPC_CWIDTH = 16;
    localparam int unsigned DEF_POST_CWIDTH = 16;

    // Stage index owned by a stage state (IDLE maps to DATA but is never used).
    function automatic logic [1:0] stage_idx(input seq_state_e st);
        case (st)
            ST_WICP: return STG_WICP;
            ST_TMPC: return STG_TMPC;
            ST_POST: return STG_POST;
            default: return STG_DATA;
        endcase
    endfunction

    // Stage that follows a given stage; POST wraps back to IDLE.
    function automatic seq_state_e next_stage(input seq_state_e st);
        case (st)
            ST_DATA: return ST_WICP;
            ST_WICP: return ST_TMPC;
            ST_TMPC: return ST_POST;
            default: return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/cfg_seq_wdog.sv
// Per-stage watchdog: counts cycles spent in a stage, flags when TIMEOUT is reached.
// Latency: expired is combinational from the registered count and en.
// Backpressure: none; clr has priority over en, count saturates.
module cfg_seq_wdog #(
    parameter int unsigned       TWIDTH  = 16,
    parameter logic [TWIDTH-1:0] TIMEOUT = 16'hFFFF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TWIDTH-1:0] r_cnt;
    logic [TWIDTH:0]   w_inc;

    // One extra bit so the increment never wraps before the compare.
    assign w_inc   = {1'b0, r_cnt} + {{TWIDTH{1'b0}}, 1'b1};

    // Expiry is judged on the count the current cycle brings it to, so a
    // stage gets exactly TIMEOUT cycles before the FSM is told to abort.
    assign expired = en && (w_inc >= {1'b0, TIMEOUT});

    // Cycle counter: cleared on stage entry, advanced each cycle in a stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en && !w_inc[TWIDTH]) begin
            r_cnt <= w_inc[TWIDTH-1:0];
        end
    end

endmodule

// File: rtl/cfg_sequencer.sv
// Config sequencer: latches one packet, runs DATA->WICP->TMPC->POST with start/done handshakes.
// Latency: accept -> data_start next cycle; stage done -> next start (or seq_done) next cycle.
// Backpressure: cfg_busy high for the whole sequence; cfg_valid while busy is dropped, not queued.
// Optional watchdog abort (seq_error) is built only when CFG_SEQ_TIMEOUT_EN is defined.
module cfg_sequencer
    import cfg_seq_pkg::*;
#(
    parameter int unsigned       DATA_CWIDTH = DEF_DATA_CWIDTH,
    parameter int unsigned       WICP_CWIDTH = DEF_WICP_CWIDTH,
    parameter int unsigned       TMPC_CWIDTH = DEF_TMPC_CWIDTH,
    parameter int unsigned       POST_CWIDTH = DEF_POST_CWIDTH,
    parameter int unsigned       TWIDTH      = 16,
    parameter logic [TWIDTH-1:0] TIMEOUT     = 16'hFFFF
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   cfg_valid,
    output logic                   cfg_busy,
    input  logic [DATA_CWIDTH-1:0] cfg_data_data,
    input  logic [WICP_CWIDTH-1:0] cfg_wicp_data,
    input  logic [TMPC_CWIDTH-1:0] cfg_tmpc_data,
    input  logic [POST_CWIDTH-1:0] cfg_post_data,

    output logic                   data_start,
    output logic [DATA_CWIDTH-1:0] data_cfg,
    input  logic                   data_done,

    output logic                   wicp_start,
    output logic [WICP_CWIDTH-1:0] wicp_cfg,
    input  logic                   wicp_done,

    output logic                   tmpc_start,
    output logic [TMPC_CWIDTH-1:0] tmpc_cfg,
    input  logic                   tmpc_done,

    output logic                   post_start,
    output logic [POST_CWIDTH-1:0] post_cfg,
    input  logic                   post_done,

    output logic                   seq_done,
    output logic                   seq_error
);

    // A watchdog limit below 2 would let a stage expire in its own start
    // cycle, before any done could ever be honoured.
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("cfg_sequencer: TIMEOUT must be at least 2");
    end

    seq_state_e             r_state;
    seq_state_e             w_state_nxt;
    logic                   r_busy;
    logic [NUM_STAGES-1:0]  r_start;
    logic [NUM_STAGES-1:0]  w_start_nxt;
    logic                   r_seq_done;
    logic                   w_seq_done_nxt;
    logic                   r_seq_error;
    logic                   w_seq_error_nxt;
    logic                   w_accept;
    logic [NUM_STAGES-1:0]  w_done_vec;
    logic                   w_done_hon;
    logic                   w_wd_expired;

    logic [DATA_CWIDTH-1:0] r_data_cfg;
    logic [WICP_CWIDTH-1:0] r_wicp_cfg;
    logic [TMPC_CWIDTH-1:0] r_tmpc_cfg;
    logic [POST_CWIDTH-1:0] r_post_cfg;

    assign w_done_vec = {post_done, tmpc_done, wicp_done, data_done};

    // Only the current stage's done counts, and never in its start cycle;
    // r_start doubles as the "first cycle in this stage" flag.
    assign w_done_hon = (r_state != ST_IDLE) && !(|r_start)
                        && w_done_vec[stage_idx(r_state)];

    assign w_accept   = (r_state == ST_IDLE) && cfg_valid && !r_busy;

`ifdef CFG_SEQ_TIMEOUT_EN
    logic w_wd_clr;
    logic w_wd_en;

    // Restart the count on every stage entry; count only while in a stage.
    assign w_wd_clr = |w_start_nxt;
    assign w_wd_en  = (r_state != ST_IDLE);

    cfg_seq_wdog #(
        .TWIDTH  (TWIDTH),
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (w_wd_clr),
        .en      (w_wd_en),
        .expired (w_wd_expired)
    );
`else
    assign w_wd_expired = 1'b0;
`endif

    // Next-state and next-output decode; done beats watchdog on the same edge.
    always_comb begin
        w_state_nxt     = r_state;
        w_start_nxt     = '0;
        w_seq_done_nxt  = 1'b0;
        w_seq_error_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt           = ST_DATA;
                    w_start_nxt[STG_DATA] = 1'b1;
                end
            end
            ST_DATA, ST_WICP, ST_TMPC, ST_POST: begin
                if (w_done_hon) begin
                    w_state_nxt = next_stage(r_state);
                    if (r_state == ST_POST) begin
                        w_seq_done_nxt = 1'b1;
                    end else begin
                        w_start_nxt[stage_idx(next_stage(r_state))] = 1'b1;
                    end
                end else if (w_wd_expired) begin
                    w_state_nxt     = ST_IDLE;
                    w_seq_error_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register plus registered busy and pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_start     <= '0;
            r_seq_done  <= 1'b0;
            r_seq_error <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_start     <= w_start_nxt;
            r_seq_done  <= w_seq_done_nxt;
            r_seq_error <= w_seq_error_nxt;
        end
    end

    // Config words are captured on accept and held until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_cfg <= '0;
            r_wicp_cfg <= '0;
            r_tmpc_cfg <= '0;
            r_post_cfg <= '0;
        end else if (w_accept) begin
            r_data_cfg <= cfg_data_data;
            r_wicp_cfg <= cfg_wicp_data;
            r_tmpc_cfg <= cfg_tmpc_data;
            r_post_cfg <= cfg_post_data;
        end
    end

    assign cfg_busy   = r_busy;
    assign data_start = r_start[STG_DATA];
    assign wicp_start = r_start[STG_WICP];
    assign tmpc_start = r_start[STG_TMPC];
    assign post_start = r_start[STG_POST];
    assign data_cfg   = r_data_cfg;
    assign wicp_cfg   = r_wicp_cfg;
    assign tmpc_cfg   = r_tmpc_cfg;
    assign post_cfg   = r_post_cfg;
    assign seq_done   = r_seq_done;
    assign seq_error  = r_seq_error;

endmodule

// File: tb/tb_cfg_sequencer.sv
// Directed bench for cfg_sequencer: ordering, back-to-back, stray dones, async reset, watchdog.
// Latency: checks are cycle-exact against hand-derived timing.
// Backpressure: cfg_valid held high across a sequence must yield one accept per sequence.
module tb_cfg_sequencer;

    logic        clk;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_busy;
    logic [31:0] cfg_data_data;
    logic [31:0] cfg_wicp_data;
    logic [15:0] cfg_tmpc_data;
    logic [15:0] cfg_post_data;
    logic        data_start, wicp_start, tmpc_start, post_start;
    logic [31:0] data_cfg;
    logic [31:0] wicp_cfg;
    logic [15:0] tmpc_cfg;
    logic [15:0] post_cfg;
    logic [3:0]  done_v;
    logic        seq_done;
    logic        seq_error;

    int n_cmp;
    int n_bad;
    int seq_len;

    cfg_sequencer #(
        .DATA_CWIDTH (32),
        .WICP_CWIDTH (32),
        .TMPC_CWIDTH (16),
        .POST_CWIDTH (16),
        .TWIDTH      (16),
        .TIMEOUT     (16'd10)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_valid     (cfg_valid),
        .cfg_busy      (cfg_busy),
        .cfg_data_data (cfg_data_data),
        .cfg_wicp_data (cfg_wicp_data),
        .cfg_tmpc_data (cfg_tmpc_data),
        .cfg_post_data (cfg_post_data),
        .data_start    (data_start),
        .data_cfg      (data_cfg),
        .data_done     (done_v[0]),
        .wicp_start    (wicp_start),
        .wicp_cfg      (wicp_cfg),
        .wicp_done     (done_v[1]),
        .tmpc_start    (tmpc_start),
        .tmpc_cfg      (tmpc_cfg),
        .tmpc_done     (done_v[2]),
        .post_start    (post_start),
        .post_cfg      (post_cfg),
        .post_done     (done_v[3]),
        .seq_done      (seq_done),
        .seq_error     (seq_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and land 1 ns after the edge, where outputs are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_pkt(input logic [31:0] d, input logic [31:0] w,
                            input logic [15:0] t, input logic [15:0] p);
        cfg_data_data = d;
        cfg_wicp_data = w;
        cfg_tmpc_data = t;
        cfg_post_data = p;
    endtask

    // Called in cycle 1 after an accept edge. Returns each stage's done `dly`
    // cycles after its start, checks start order and held cfg words, and
    // returns with the seq_done cycle sampled; len = cycles accept->seq_done.
    task automatic run_seq(input int dly, input logic [31:0] exp_d,
                           input logic [15:0] exp_p, output int len);
        logic [3:0] st;
        int order;
        int pend_cyc;
        int pend_idx;
        order    = 0;
        pend_cyc = -1;
        pend_idx = 0;
        len      = -1;
        for (int c = 1; c <= 60; c++) begin
            done_v = 4'b0000;
            st = {post_start, tmpc_start, wicp_start, data_start};
            if (st != 4'b0000) begin
                chk("start_order", {28'd0, st}, 32'd1 << order);
                pend_idx = order;
                pend_cyc = c + dly;
                order++;
            end
            chk("data_cfg_held", data_cfg, exp_d);
            chk("post_cfg_held", {16'd0, post_cfg}, {16'd0, exp_p});
            if (seq_done) begin
                chk("seq_done_busy_low", {31'd0, cfg_busy}, 32'd0);
                chk("starts_seen", order, 4);
                len = c - 1;
                break;
            end
            chk("busy_in_seq", {31'd0, cfg_busy}, 32'd1);
            chk("no_seq_error", {31'd0, seq_error}, 32'd0);
            if (c == pend_cyc) done_v[pend_idx] = 1'b1;
            tick();
        end
        if (len < 0) chk("seq_done_seen", 32'd0, 32'd1);
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b1;
        cfg_valid = 1'b0;
        done_v    = 4'b0000;
        load_pkt(32'd0, 32'd0, 16'd0, 16'd0);

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy",  {31'd0, cfg_busy}, 32'd0);
        chk("rst_start", {28'd0, post_start, tmpc_start, wicp_start, data_start}, 32'd0);
        chk("rst_done",  {30'd0, seq_done, seq_error}, 32'd0);
        chk("rst_cfg",   data_cfg | wicp_cfg | {16'd0, tmpc_cfg} | {16'd0, post_cfg}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single packet, dones 3 cycles after each start
        load_pkt(32'hA5A5_0001, 32'h1234_5678, 16'hBEEF, 16'h00FF);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        load_pkt(32'h0, 32'h0, 16'h0, 16'h0);
        chk("t1_wicp_cfg", wicp_cfg, 32'h1234_5678);
        chk("t1_tmpc_cfg", {16'd0, tmpc_cfg}, 32'h0000_BEEF);
        run_seq(3, 32'hA5A5_0001, 16'h00FF, seq_len);
        chk("t1_len", seq_len, 16);
        tick();
        chk("t1_done_pulse", {31'd0, seq_done}, 32'd0);
        chk("t1_cfg_kept", {16'd0, post_cfg}, 32'h0000_00FF);

        // cfg_valid held high: minimum length, back-to-back accept
        load_pkt(32'h1111_0002, 32'h2222_0002, 16'h3333, 16'h4444);
        cfg_valid = 1'b1;
        tick();
        load_pkt(32'h5555_0003, 32'h6666_0003, 16'h7777, 16'h8888);
        run_seq(1, 32'h1111_0002, 16'h4444, seq_len);
        chk("t2_min_len", seq_len, 8);
        tick();
        chk("t2_b2b_start", {31'd0, data_start}, 32'd1);
        chk("t2_b2b_busy",  {31'd0, cfg_busy}, 32'd1);
        cfg_valid = 1'b0;
        run_seq(1, 32'h5555_0003, 16'h8888, seq_len);
        chk("t2_len2", seq_len, 8);
        tick();
        chk("t2_idle_after", {31'd0, cfg_busy}, 32'd0);

        // Stray dones in DATA are ignored
        load_pkt(32'hDEAD_0004, 32'hCAFE_0004, 16'h0104, 16'h0204);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("t3_data_start", {31'd0, data_start}, 32'd1);
        done_v = 4'b0101;
        tick();
        done_v = 4'b0100;
        chk("t3_no_adv_a", {31'd0, wicp_start}, 32'd0);
        tick();
        done_v = 4'b0000;
        chk("t3_no_adv_b", {29'd0, tmpc_start, wicp_start, cfg_busy}, 32'd1);
        done_v = 4'b0001;
        tick();
        done_v = 4'b0000;
        chk("t3_wicp_start", {31'd0, wicp_start}, 32'd1);
        chk("t3_wicp_cfg", wicp_cfg, 32'hCAFE_0004);

        // Async reset while in WICP
        #3 rst_n = 1'b0;
        #1;
        chk("t4_rst_busy",  {31'd0, cfg_busy}, 32'd0);
        chk("t4_rst_start", {31'd0, wicp_start}, 32'd0);
        chk("t4_rst_cfg",   wicp_cfg, 32'd0);
        tick();
        tick();
        chk("t4_no_seq_done", {30'd0, seq_done, seq_error}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("t4_still_idle", {31'd0, cfg_busy}, 32'd0);
        load_pkt(32'h0BAD_0005, 32'h0, 16'h0, 16'h0055);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        run_seq(2, 32'h0BAD_0005, 16'h0055, seq_len);
        chk("t4_len", seq_len, 12);
        tick();

`ifdef CFG_SEQ_TIMEOUT_EN
        // Watchdog: wicp_done never comes
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        tick();
        done_v[0] = 1'b1;
        tick();
        done_v = 4'b0000;
        chk("t5_wicp_start", {31'd0, wicp_start}, 32'd1);
        for (int k = 1; k <= 10; k++) begin
            chk("t5_wait", {29'd0, tmpc_start, seq_error, cfg_busy}, 32'd1);
            tick();
        end
        chk("t5_err_pulse", {31'd0, seq_error}, 32'd1);
        chk("t5_err_busy",  {30'd0, tmpc_start, cfg_busy}, 32'd0);
        tick();
        chk("t5_err_once",  {30'd0, seq_error, tmpc_start}, 32'd0);

        // Watchdog: done on the expiry edge wins
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        tick();
        done_v[0] = 1'b1;
        tick();
        done_v = 4'b0000;
        chk("t6_wicp_start", {31'd0, wicp_start}, 32'd1);
        for (int k = 1; k <= 9; k++) begin
            tick();
        end
        done_v[1] = 1'b1;
        tick();
        done_v = 4'b0000;
        chk("t6_tmpc_start", {31'd0, tmpc_start}, 32'd1);
        chk("t6_no_err",     {30'd0, seq_error, cfg_busy}, 32'd1);
        tick();
        done_v[2] = 1'b1;
        tick();
        done_v = 4'b0000;
        chk("t6_post_start", {31'd0, post_start}, 32'd1);
        tick();
        done_v[3] = 1'b1;
        tick();
        done_v = 4'b0000;
        chk("t6_seq_done", {30'd0, seq_done, seq_error}, 32'd2);
        tick();
`else
        // Without the watchdog, a missing done stalls indefinitely
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        tick();
        done_v[0] = 1'b1;
        tick();
        done_v = 4'b0000;
        for (int k = 1; k <= 30; k++) tick();
        chk("t5_stall", {29'd0, tmpc_start, seq_error, cfg_busy}, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cfg_sequencer.md
# cfg_sequencer

Configuration sequencer for the PE-array datapath. It owns the top-level `cfg_valid`/`cfg_busy` handshake, latches one configuration packet, and runs the four datapath stages strictly in order: DATA, WICP, TMPC, POST. Each stage receives a start pulse and a held config word, and the sequencer waits for that stage's done before starting the next. It sits between the top-level cfg ports and the stage controllers.

## Interface
Parameters:
- `DATA_CWIDTH`, 32: width of the DATA stage config word.
- `WICP_CWIDTH`, 32: width of the WICP stage config word.
- `TMPC_CWIDTH`, 16: width of the TMPC stage config word.
- `POST_CWIDTH`, 16: width of the POST stage config word.
- `TWIDTH`, 16: width of the watchdog counter. Used only with `CFG_SEQ_TIMEOUT_EN`.
- `TIMEOUT`, 16'hFFFF: per-stage cycle limit, compared with `>=`. Must be ≥ 2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cfg_valid`  in  1  config packet present.
- `cfg_busy`  out  1  sequence in progress; packets are not accepted while high.
- `cfg_data_data`  in  DATA_CWIDTH  DATA stage config.
- `cfg_wicp_data`  in  WICP_CWIDTH  WICP stage config.
- `cfg_tmpc_data`  in  TMPC_CWIDTH  TMPC stage config.
- `cfg_post_data`  in  POST_CWIDTH  POST stage config.
- `<s>_start`  out  1  one-cycle start pulse, where s ∈ {data, wicp, tmpc, post}.
- `<s>_cfg`  out  matching width  latched config for stage s.
- `<s>_done`  in  1  stage s completion; treated as a single-cycle pulse.
- `seq_done`  out  1  one-cycle pulse when the sequence ends normally.
- `seq_error`  out  1  one-cycle pulse when the sequence is aborted by the watchdog.

## Operation
- States are IDLE, DATA, WICP, TMPC, POST.
- Accept condition: `cfg_valid && !cfg_busy` at a rising edge.
  - All four cfg words are latched into the `<s>_cfg` registers.
  - The FSM moves IDLE→DATA.
- `cfg_valid` while busy is ignored. It is neither queued nor an error.
- Stage start pulse:
  - On entry to a stage state, that stage's `<s>_start` is high for exactly the first cycle in the state.
  - At most one `<s>_start` is high in any cycle.
- Stage done handling:
  - In a stage state, `<s>_done` is honoured only after its start cycle. Done in the start cycle itself is ignored.
  - Honoured done advances DATA→WICP→TMPC→POST.
  - POST with honoured done → IDLE, with `seq_done` pulsed.
- Done inputs of non-current stages, and any done in IDLE, are ignored.
- `cfg_busy` is high exactly when state ≠ IDLE. It is registered.
- `<s>_cfg` holds its value from accept until the next accept. It is not cleared on return to IDLE.
- Reset mid-sequence:
  - State returns to IDLE.
  - All outputs go to 0 immediately (asynchronous).
  - No `seq_done` or `seq_error` is generated.

## Timing
- Reset values:
  - `cfg_busy`, all `<s>_start`, `seq_done`, `seq_error`: 0.
  - All `<s>_cfg`: 0.
- Accept at edge T0 → in cycle T0+1: `cfg_busy`=1 and `data_start`=1.
- `<s>_done` sampled at edge Tk → in cycle Tk+1: next stage's `_start`=1.
- `post_done` sampled at edge Tk → in cycle Tk+1: `seq_done`=1 and `cfg_busy`=0.
- Back-to-back sequences: a new packet can be accepted at the edge ending the `seq_done` cycle.
- Minimum sequence length: 8 cycles from accept to `seq_done`, with every done arriving in the cycle after its start.

## Configuration
- Macro `CFG_SEQ_TIMEOUT_EN`.
- Defined:
  - A watchdog counter clears on entry to each stage state and increments every cycle in that state.
  - If the count reaches `>= TIMEOUT` before an honoured done, the FSM goes to IDLE.
  - `seq_error` pulses for one cycle, in the same cycle `cfg_busy` falls.
  - The remaining stages are not started.
  - If done and timeout occur on the same edge, done wins.
- Not defined:
  - No counter is instantiated; `TWIDTH` and `TIMEOUT` are unused.
  - `seq_error` is tied to 0.
  - The FSM waits indefinitely for each done.

## Structure
- Shared package `cfg_seq_pkg`:
  - State enum: IDLE, DATA, WICP, TMPC, POST.
  - Stage index constants 0–3.
  - Default widths for the four cfg words.
- Sub-module `cfg_seq_wdog`:
  - Ports: `clk`, `rst_n`, `clr`, `en`, `expired`.
  - Parameterised by `TWIDTH` and `TIMEOUT`.
  - Instantiated only under `CFG_SEQ_TIMEOUT_EN`.

## Test plan
- Reset, then one packet (`cfg_data_data`=32'hA5A5_0001, `cfg_post_data`=16'h00FF), with each done returned 3 cycles after its start.
  - Starts appear in the order data, wicp, tmpc, post.
  - `post_cfg`=16'h00FF is held throughout.
  - `seq_done` is high in the cycle after `post_done`; `cfg_busy` falls in that same cycle.
- `cfg_valid` held high continuously.
  - Exactly one accept per sequence.
  - The second accept occurs at the edge ending the `seq_done` cycle.
  - 8-cycle minimum with immediate dones.
- Stray dones:
  - `tmpc_done` pulsed during DATA, and `data_done` in the `data_start` cycle, are both ignored.
  - The FSM advances only on a valid `data_done`.
- `rst_n` dropped asynchronously in the WICP state.
  - All outputs become 0 immediately.
  - No `seq_done`.
  - A fresh packet is accepted normally after release.
- With `CFG_SEQ_TIMEOUT_EN` and `TIMEOUT`=10, `wicp_done` never asserted.
  - `seq_error` pulses after 10 cycles in WICP.
  - `tmpc_start` is never asserted.
  - `cfg_busy` goes to 0.
- With `CFG_SEQ_TIMEOUT_EN`, `wicp_done` arrives on the same edge as expiry.
  - The FSM advances to TMPC.
  - `seq_error` stays 0.
